// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared RV32I control-field encodings for controller and encoder
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [8:0] T_R      = 9'b100000000;
    localparam logic [8:0] T_I      = 9'b010000000;
    localparam logic [8:0] T_LOAD   = 9'b001000000;
    localparam logic [8:0] T_STORE  = 9'b000100000;
    localparam logic [8:0] T_BRANCH = 9'b000010000;
    localparam logic [8:0] T_JAL    = 9'b000001000;
    localparam logic [8:0] T_LUI    = 9'b000000100;
    localparam logic [8:0] T_AUIPC  = 9'b000000010;
    localparam logic [8:0] T_JALR   = 9'b000000001;
    localparam logic [8:0] T_NOP    = 9'b000000000;

    localparam logic [5:0] ALU_ADD   = 6'd0;
    localparam logic [5:0] ALU_SUB   = 6'd1;
    localparam logic [5:0] ALU_XOR   = 6'd2;
    localparam logic [5:0] ALU_OR    = 6'd3;
    localparam logic [5:0] ALU_AND   = 6'd4;
    localparam logic [5:0] ALU_SLL   = 6'd5;
    localparam logic [5:0] ALU_SRL   = 6'd6;
    localparam logic [5:0] ALU_SRA   = 6'd7;
    localparam logic [5:0] ALU_SLT   = 6'd8;
    localparam logic [5:0] ALU_SLTU  = 6'd9;
    localparam logic [5:0] ALU_ADDI  = 6'd10;
    localparam logic [5:0] ALU_XORI  = 6'd11;
    localparam logic [5:0] ALU_ORI   = 6'd12;
    localparam logic [5:0] ALU_ANDI  = 6'd13;
    localparam logic [5:0] ALU_SLLI  = 6'd14;
    localparam logic [5:0] ALU_SRLI  = 6'd15;
    localparam logic [5:0] ALU_SRAI  = 6'd16;
    localparam logic [5:0] ALU_SLTI  = 6'd17;
    localparam logic [5:0] ALU_SLTIU = 6'd18;
    localparam logic [5:0] ALU_AUIPC = 6'd19;

    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLT  = 4'd3;
    localparam logic [3:0] BR_BGE  = 4'd4;
    localparam logic [3:0] BR_BLTU = 4'd5;
    localparam logic [3:0] BR_BGEU = 4'd6;

    typedef enum logic [2:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    function automatic logic [2:0] alu_funct3(input logic [5:0] op);
        case (op)
            ALU_SLL,  ALU_SLLI:                     return 3'd1;
            ALU_SLT,  ALU_SLTI:                     return 3'd2;
            ALU_SLTU, ALU_SLTIU:                    return 3'd3;
            ALU_XOR,  ALU_XORI:                     return 3'd4;
            ALU_SRL,  ALU_SRA, ALU_SRLI, ALU_SRAI:  return 3'd5;
            ALU_OR,   ALU_ORI:                      return 3'd6;
            ALU_AND,  ALU_ANDI:                     return 3'd7;
            default:                                return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] br_funct3(input logic [3:0] br);
        case (br)
            BR_BEQ:  return 3'd0;
            BR_BNE:  return 3'd1;
            BR_BLT:  return 3'd4;
            BR_BGE:  return 3'd5;
            BR_BLTU: return 3'd6;
            BR_BGEU: return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field input / instruction output bus; ENC_MNEMONIC_EN adds char_out
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [8:0]        type_oh;
    logic [5:0]        alu_op;
    logic [3:0]        branch;
    logic [2:0]        mem_f3;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       immediate;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       instr;
    logic              illegal;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        illegal_count;
`ifdef ENC_MNEMONIC_EN
    logic [39:0]       char_out;

    modport master (
        output in_valid, type_oh, alu_op, branch, mem_f3, rs1, rs2, rd, immediate, out_ready,
        input  in_ready, out_valid, instr, illegal, mem_addr, illegal_count, char_out
    );
    modport slave (
        input  in_valid, type_oh, alu_op, branch, mem_f3, rs1, rs2, rd, immediate, out_ready,
        output in_ready, out_valid, instr, illegal, mem_addr, illegal_count, char_out
    );
`else
    modport master (
        output in_valid, type_oh, alu_op, branch, mem_f3, rs1, rs2, rd, immediate, out_ready,
        input  in_ready, out_valid, instr, illegal, mem_addr, illegal_count
    );
    modport slave (
        input  in_valid, type_oh, alu_op, branch, mem_f3, rs1, rs2, rd, immediate, out_ready,
        output in_ready, out_valid, instr, illegal, mem_addr, illegal_count
    );
`endif
endinterface

// File: rtl/imm_packer.sv
// rtl/imm_packer.sv - places an immediate into its R/I/S/B/U/J bit positions and flags range errors
module imm_packer
    import rv_ctrl_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [31:0] imm,
    output logic [31:0] imm_bits,
    output logic        range_fail
);

    always_comb begin
        imm_bits   = '0;
        range_fail = 1'b0;
        case (fmt)
            FMT_I: begin
                imm_bits[31:20] = imm[11:0];
                range_fail      = ($signed(imm) > 32'sd2047) || ($signed(imm) < -32'sd2048);
            end
            FMT_SH: begin
                imm_bits[24:20] = imm[4:0];
                range_fail      = (imm[31:5] != '0);
            end
            FMT_S: begin
                imm_bits[31:25] = imm[11:5];
                imm_bits[11:7]  = imm[4:0];
                range_fail      = ($signed(imm) > 32'sd2047) || ($signed(imm) < -32'sd2048);
            end
            FMT_B: begin
                imm_bits[31]    = imm[12];
                imm_bits[30:25] = imm[10:5];
                imm_bits[11:8]  = imm[4:1];
                imm_bits[7]     = imm[11];
                range_fail      = imm[0] || ($signed(imm) > 32'sd4095) || ($signed(imm) < -32'sd4096);
            end
            FMT_U: begin
                imm_bits[31:12] = imm[31:12];
                range_fail      = (imm[11:0] != '0);
            end
            FMT_J: begin
                imm_bits[31]    = imm[20];
                imm_bits[30:21] = imm[10:1];
                imm_bits[20]    = imm[11];
                imm_bits[19:12] = imm[19:12];
                range_fail      = imm[0] || ($signed(imm) > 32'sd1048575) ||
                                  ($signed(imm) < -32'sd1048576);
            end
            default: begin
                imm_bits   = '0;
                range_fail = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - two-stage RV32I instruction encoder with sequential write addresses
// Optional feature macro ENC_MNEMONIC_EN adds the char_out ASCII mnemonic.
module instr_encoder
    import rv_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic           clock,
    input  logic           reset,
    instr_encoder_if.slave bus
);

    logic [6:0]        d_opcode;
    logic [2:0]        d_f3;
    logic [6:0]        d_f7;
    fmt_e              d_fmt;
    logic              d_bad;
    logic              d_use_rd, d_use_rs1, d_use_rs2;

    logic              s1_valid;
    logic [6:0]        s1_opcode;
    logic [2:0]        s1_f3;
    logic [6:0]        s1_f7;
    fmt_e              s1_fmt;
    logic              s1_bad;
    logic [4:0]        s1_rd, s1_rs1, s1_rs2;
    logic [31:0]       s1_imm;

    logic              s2_valid;
    logic [31:0]       instr_q;
    logic              illegal_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        ill_cnt_q;

    logic              s1_adv;
    logic              s1_load;
    logic [31:0]       imm_bits;
    logic              range_fail;
    logic              s2_ill;
    logic [31:0]       s2_word;

    always_comb begin
        d_opcode  = 7'd0;
        d_f3      = 3'd0;
        d_f7      = 7'd0;
        d_fmt     = FMT_NONE;
        d_use_rd  = 1'b0;
        d_use_rs1 = 1'b0;
        d_use_rs2 = 1'b0;
        d_bad     = ((bus.type_oh & (bus.type_oh - 9'd1)) != 9'd0);
        case (bus.type_oh)
            T_R: begin
                d_opcode = OP_R;
                d_fmt    = FMT_R;
                d_f3     = alu_funct3(bus.alu_op);
                d_f7     = (bus.alu_op == ALU_SUB || bus.alu_op == ALU_SRA) ? 7'h20 : 7'h00;
                d_bad    = (bus.alu_op > ALU_SLTU);
                {d_use_rd, d_use_rs1, d_use_rs2} = 3'b111;
            end
            T_I: begin
                d_opcode = OP_I;
                d_fmt    = (bus.alu_op inside {ALU_SLLI, ALU_SRLI, ALU_SRAI}) ? FMT_SH : FMT_I;
                d_f3     = alu_funct3(bus.alu_op);
                d_f7     = (bus.alu_op == ALU_SRAI) ? 7'h20 : 7'h00;
                d_bad    = (bus.alu_op < ALU_ADDI) || (bus.alu_op > ALU_SLTIU);
                {d_use_rd, d_use_rs1} = 2'b11;
            end
            T_LOAD: begin
                d_opcode = OP_LOAD;
                d_fmt    = FMT_I;
                d_f3     = bus.mem_f3;
                d_bad    = !(bus.mem_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                {d_use_rd, d_use_rs1} = 2'b11;
            end
            T_STORE: begin
                d_opcode = OP_STORE;
                d_fmt    = FMT_S;
                d_f3     = bus.mem_f3;
                d_bad    = (bus.mem_f3 > 3'd2);
                {d_use_rs1, d_use_rs2} = 2'b11;
            end
            T_BRANCH: begin
                d_opcode = OP_BRANCH;
                d_fmt    = FMT_B;
                d_f3     = br_funct3(bus.branch);
                d_bad    = (bus.branch < BR_BEQ) || (bus.branch > BR_BGEU);
                {d_use_rs1, d_use_rs2} = 2'b11;
            end
            T_JAL:   begin d_opcode = OP_JAL; d_fmt = FMT_J; d_use_rd = 1'b1; end
            T_LUI:   begin d_opcode = OP_LUI; d_fmt = FMT_U; d_use_rd = 1'b1; end
            T_AUIPC: begin
                d_opcode = OP_AUIPC;
                d_fmt    = FMT_U;
                d_bad    = (bus.alu_op != ALU_AUIPC);
                d_use_rd = 1'b1;
            end
            T_JALR:  begin d_opcode = OP_JALR; d_fmt = FMT_I; {d_use_rd, d_use_rs1} = 2'b11; end
            T_NOP:   d_fmt = FMT_NONE;
            default: d_fmt = FMT_NONE;
        endcase
    end

    assign s1_adv       = !s2_valid || bus.out_ready;
    assign s1_load      = !s1_valid || s1_adv;
    assign bus.in_ready = !reset && s1_load;

    imm_packer u_imm_packer (
        .fmt        (s1_fmt),
        .imm        (s1_imm),
        .imm_bits   (imm_bits),
        .range_fail (range_fail)
    );

    // Unused register fields are zeroed in S1, so a plain OR with the immediate bits is safe.
    assign s2_ill  = s1_bad || range_fail;
    assign s2_word = s2_ill ? 32'd0 :
                     ({s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_opcode} | imm_bits);

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_opcode  <= '0;
            s1_f3      <= '0;
            s1_f7      <= '0;
            s1_fmt     <= FMT_NONE;
            s1_bad     <= 1'b0;
            s1_rd      <= '0;
            s1_rs1     <= '0;
            s1_rs2     <= '0;
            s1_imm     <= '0;
            s2_valid   <= 1'b0;
            instr_q    <= '0;
            illegal_q  <= 1'b0;
            mem_addr_q <= '0;
            ill_cnt_q  <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_opcode <= d_opcode;
                    s1_f3     <= d_f3;
                    s1_f7     <= d_f7;
                    s1_fmt    <= d_fmt;
                    s1_bad    <= d_bad;
                    s1_rd     <= d_use_rd  ? bus.rd  : 5'd0;
                    s1_rs1    <= d_use_rs1 ? bus.rs1 : 5'd0;
                    s1_rs2    <= d_use_rs2 ? bus.rs2 : 5'd0;
                    s1_imm    <= bus.immediate;
                end
            end
            if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    instr_q   <= s2_word;
                    illegal_q <= s2_ill;
                    if (s2_ill && ill_cnt_q != 8'hFF) begin
                        ill_cnt_q <= ill_cnt_q + 8'd1;
                    end
                end
            end
            if (s2_valid && bus.out_ready) begin
                mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
        end
    end

    assign bus.out_valid     = s2_valid;
    assign bus.instr         = instr_q;
    assign bus.illegal       = illegal_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.illegal_count = ill_cnt_q;

`ifdef ENC_MNEMONIC_EN
    logic [39:0] s1_mnem;
    logic [39:0] char_q;

    function automatic logic [39:0] mnemonic(input logic [8:0] t, input logic [5:0] op,
                                             input logic [3:0] br, input logic [2:0] f3);
        logic [39:0] m;
        m = "ILL  ";
        case (t)
            T_NOP: m = "NOP  ";
            T_R, T_I: case (op)
                ALU_ADD:  m = "ADD  ";  ALU_SUB:   m = "SUB  ";  ALU_XOR:  m = "XOR  ";
                ALU_OR:   m = "OR   ";  ALU_AND:   m = "AND  ";  ALU_SLL:  m = "SLL  ";
                ALU_SRL:  m = "SRL  ";  ALU_SRA:   m = "SRA  ";  ALU_SLT:  m = "SLT  ";
                ALU_SLTU: m = "SLTU ";  ALU_ADDI:  m = "ADDI ";  ALU_XORI: m = "XORI ";
                ALU_ORI:  m = "ORI  ";  ALU_ANDI:  m = "ANDI ";  ALU_SLLI: m = "SLLI ";
                ALU_SRLI: m = "SRLI ";  ALU_SRAI:  m = "SRAI ";  ALU_SLTI: m = "SLTI ";
                ALU_SLTIU: m = "SLTIU";
                default:  m = "ILL  ";
            endcase
            T_LOAD: case (f3)
                3'd0: m = "LB   ";  3'd1: m = "LH   ";  3'd2: m = "LW   ";
                3'd4: m = "LBU  ";  3'd5: m = "LHU  ";  default: m = "ILL  ";
            endcase
            T_STORE: case (f3)
                3'd0: m = "SB   ";  3'd1: m = "SH   ";  3'd2: m = "SW   ";  default: m = "ILL  ";
            endcase
            T_BRANCH: case (br)
                BR_BEQ:  m = "BEQ  ";  BR_BNE:  m = "BNE  ";  BR_BLT:  m = "BLT  ";
                BR_BGE:  m = "BGE  ";  BR_BLTU: m = "BLTU ";  BR_BGEU: m = "BGEU ";
                default: m = "ILL  ";
            endcase
            T_JAL:   m = "JAL  ";
            T_LUI:   m = "LUI  ";
            T_AUIPC: m = "AUIPC";
            T_JALR:  m = "JALR ";
            default: m = "ILL  ";
        endcase
        return m;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_mnem <= "XXXXX";
            char_q  <= "XXXXX";
        end else begin
            if (s1_load && bus.in_valid) begin
                s1_mnem <= mnemonic(bus.type_oh, bus.alu_op, bus.branch, bus.mem_f3);
            end
            if (s1_adv && s1_valid) begin
                char_q <= s2_ill ? "ILL  " : s1_mnem;
            end
        end
    end

    assign bus.char_out = char_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder (ADDR_W=8 and ADDR_W=2 instances)
module tb_instr_encoder;
    import rv_ctrl_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic        ill;
        logic [7:0]  addr;
        logic [7:0]  cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    instr_encoder_if #(.ADDR_W(8)) bus ();
    instr_encoder_if #(.ADDR_W(2)) bus2 ();

    instr_encoder #(.ADDR_W(8)) dut  (.clock(clock), .reset(reset), .bus(bus.slave));
    instr_encoder #(.ADDR_W(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));

    exp_t       q1[$];
    exp_t       q2[$];
    int         vectors    = 0;
    int         miscompares = 0;
    logic [7:0] exp_addr   = 8'd0;
    logic [7:0] exp_cnt    = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] ei, input logic eill);
        exp_t e;
        if (eill && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        e.instr = ei;
        e.ill   = eill;
        e.addr  = exp_addr;
        e.cnt   = exp_cnt;
        q1.push_back(e);
        q2.push_back(e);
        exp_addr = exp_addr + 8'd1;
    endtask

    task automatic drive(input logic v, input logic [8:0] t, input logic [5:0] op,
                         input logic [3:0] br, input logic [2:0] f3, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] d, input logic [31:0] imm);
        bus.in_valid  = v;  bus2.in_valid  = v;
        bus.type_oh   = t;  bus2.type_oh   = t;
        bus.alu_op    = op; bus2.alu_op    = op;
        bus.branch    = br; bus2.branch    = br;
        bus.mem_f3    = f3; bus2.mem_f3    = f3;
        bus.rs1       = r1; bus2.rs1       = r1;
        bus.rs2       = r2; bus2.rs2       = r2;
        bus.rd        = d;  bus2.rd        = d;
        bus.immediate = imm; bus2.immediate = imm;
    endtask

    task automatic set_ready(input logic r);
        bus.out_ready  = r;
        bus2.out_ready = r;
    endtask

    // Holds the word until the encoder takes it; the expectation is queued on that same edge.
    task automatic send(input logic [8:0] t, input logic [5:0] op, input logic [3:0] br,
                        input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input logic [31:0] imm,
                        input logic [31:0] ei, input logic eill);
        bit acc = 0;
        int n   = 0;
        drive(1'b1, t, op, br, f3, r1, r2, d, imm);
        while (!acc && n < 100) begin
            @(negedge clock);
            acc = bus.in_ready;
            if (acc) push(ei, eill);
            @(posedge clock);
            #1;
            n++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        drive(1'b0, T_NOP, 6'd0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_pending", q1.size() + q2.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_illegal_count", bus.illegal_count, 0);
        check("rst_mem_addr_w2", bus2.mem_addr, 0);
        q1.delete();
        q2.delete();
        exp_addr = 8'd0;
        exp_cnt  = 8'd0;
        reset    = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (q1.size() == 0) begin
                check("unexpected_word", bus.instr, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("instr", bus.instr, e.instr);
                check("illegal", bus.illegal, e.ill);
                check("mem_addr", bus.mem_addr, e.addr);
                check("illegal_count", bus.illegal_count, e.cnt);
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && bus2.out_valid && bus2.out_ready) begin
            if (q2.size() == 0) begin
                check("unexpected_word_w2", bus2.instr, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("instr_w2", bus2.instr, e.instr);
                check("mem_addr_w2", bus2.mem_addr, e.addr[1:0]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, T_NOP, 6'd0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        set_ready(1'b1);
        repeat (3) @(posedge clock);
        #1;
        do_reset();
        @(posedge clock);
        #1;
        check("in_ready_after_reset", bus.in_ready, 1);

        // add x3,x1,x2 with a two-cycle latency check
        send(T_R, ALU_ADD, 4'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
        check("lat_cycle1_out_valid", bus.out_valid, 0);
        @(posedge clock);
        #1;
        check("lat_cycle2_out_valid", bus.out_valid, 1);

        send(T_I,      ALU_ADDI,  4'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
        send(T_LUI,    6'd0,      4'd0, 3'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 32'h123452B7, 1'b0);
        send(T_BRANCH, 6'd0,      BR_BEQ, 3'd0, 5'd1, 5'd2, 5'd0, 32'd8,       32'h00208463, 1'b0);
        send(T_BRANCH, 6'd0,      BR_BEQ, 3'd0, 5'd1, 5'd2, 5'd0, 32'd7,       32'h00000000, 1'b1);
        send(T_R,      ALU_SUB,   4'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0,         32'h402081B3, 1'b0);
        send(T_R,      ALU_XOR,   4'd0, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0,         32'h0010C0B3, 1'b0);
        send(T_I,      ALU_SRAI,  4'd0, 3'd0, 5'd2, 5'd0, 5'd1, 32'd3,         32'h40315093, 1'b0);
        send(T_LOAD,   6'd0,      4'd0, 3'd2, 5'd2, 5'd0, 5'd4, 32'd16,        32'h01012203, 1'b0);
        send(T_STORE,  6'd0,      4'd0, 3'd2, 5'd2, 5'd5, 5'd0, 32'd20,        32'h00512A23, 1'b0);
        send(T_JAL,    6'd0,      4'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd8,         32'h008000EF, 1'b0);
        send(T_JALR,   6'd0,      4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'd0,         32'h00008067, 1'b0);
        send(T_AUIPC,  ALU_AUIPC, 4'd0, 3'd0, 5'd0, 5'd0, 5'd2, 32'h0000_1000, 32'h00001117, 1'b0);
        send(T_BRANCH, 6'd0,      BR_BNE, 3'd0, 5'd3, 5'd4, 5'd0, 32'hFFFF_FFFC, 32'hFE419EE3, 1'b0);
        send(T_I,      ALU_ANDI,  4'd0, 3'd0, 5'd7, 5'd0, 5'd7, 32'd2047,      32'h7FF3F393, 1'b0);
        send(T_I,      ALU_ADDI,  4'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'hFFFF_F800, 32'h80000093, 1'b0);
        send(T_NOP,    6'd0,      4'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd5,         32'h00000000, 1'b0);
        send(9'b110000000, ALU_ADD, 4'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0,       32'h00000000, 1'b1);
        send(T_R,      ALU_ADDI,  4'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0,         32'h00000000, 1'b1);
        send(T_I,      ALU_SLTU,  4'd0, 3'd0, 5'd1, 5'd0, 5'd3, 32'd0,         32'h00000000, 1'b1);
        send(T_LOAD,   6'd0,      4'd0, 3'd3, 5'd1, 5'd0, 5'd3, 32'd0,         32'h00000000, 1'b1);
        send(T_STORE,  6'd0,      4'd0, 3'd4, 5'd1, 5'd2, 5'd0, 32'd0,         32'h00000000, 1'b1);
        send(T_I,      ALU_ADDI,  4'd0, 3'd0, 5'd1, 5'd0, 5'd3, 32'd2048,      32'h00000000, 1'b1);
        send(T_I,      ALU_SLLI,  4'd0, 3'd0, 5'd1, 5'd0, 5'd3, 32'd32,        32'h00000000, 1'b1);
        send(T_JAL,    6'd0,      4'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd3,         32'h00000000, 1'b1);
        send(T_LUI,    6'd0,      4'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'h0000_1001, 32'h00000000, 1'b1);
        send(T_AUIPC,  ALU_ADD,   4'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'h0000_1000, 32'h00000000, 1'b1);
        send(T_BRANCH, 6'd0,      4'd7, 3'd0, 5'd1, 5'd2, 5'd0, 32'd8,         32'h00000000, 1'b1);
        drain();

        // Backpressure from a clean start: two words fill the pipe, the third must wait.
        do_reset();
        set_ready(1'b0);
        send(T_R, ALU_ADD, 4'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
        send(T_R, ALU_SUB, 4'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h402081B3, 1'b0);
        drive(1'b1, T_JAL, 6'd0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_hold_instr", bus.instr, 32'h002081B3);
        end
        @(posedge clock);
        #1;
        set_ready(1'b1);
        send(T_JAL, 6'd0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd8, 32'h008000EF, 1'b0);
        send(T_LUI, 6'd0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 32'h123452B7, 1'b0);
        send(T_I, ALU_ADDI, 4'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
        drain();

        // Reset while both stages hold words, one of them illegal.
        set_ready(1'b0);
        send(T_JAL, 6'd0, 4'd0, 3'd0, 5'd0, 5'd0, 5'd1, 32'd3, 32'h00000000, 1'b1);
        send(T_R, ALU_ADD, 4'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
        check("full_before_reset_count", bus.illegal_count, 8'd1);
        do_reset();
        set_ready(1'b1);
        send(T_R, ALU_ADD, 4'd0, 3'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
